// File: rtl/rop_types_pkg.sv
// Shared ROP types: colour layout, blend state, blend enums and the
// exact divide-by-255 used to renormalise 8x8 colour products.
//
// Channel layout of a 32-bit colour: a[31:24] r[23:16] g[15:8] b[7:0].
package rop_types;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgba_t;

    typedef enum logic [2:0] {
        ROP_BLEND_MODE_ADD          = 3'd0,
        ROP_BLEND_MODE_SUBTRACT     = 3'd1,
        ROP_BLEND_MODE_REV_SUBTRACT = 3'd2,
        ROP_BLEND_MODE_MIN          = 3'd3,
        ROP_BLEND_MODE_MAX          = 3'd4
    } rop_blend_mode_e;

    typedef enum logic [3:0] {
        ROP_BLEND_FUNC_ZERO                = 4'd0,
        ROP_BLEND_FUNC_ONE                 = 4'd1,
        ROP_BLEND_FUNC_SRC_COLOR           = 4'd2,
        ROP_BLEND_FUNC_ONE_MINUS_SRC_COLOR = 4'd3,
        ROP_BLEND_FUNC_DST_COLOR           = 4'd4,
        ROP_BLEND_FUNC_ONE_MINUS_DST_COLOR = 4'd5,
        ROP_BLEND_FUNC_SRC_ALPHA           = 4'd6,
        ROP_BLEND_FUNC_ONE_MINUS_SRC_ALPHA = 4'd7,
        ROP_BLEND_FUNC_DST_ALPHA           = 4'd8,
        ROP_BLEND_FUNC_ONE_MINUS_DST_ALPHA = 4'd9,
        ROP_BLEND_FUNC_CONST_COLOR         = 4'd10,
        ROP_BLEND_FUNC_ONE_MINUS_CONST_COLOR = 4'd11,
        ROP_BLEND_FUNC_CONST_ALPHA         = 4'd12,
        ROP_BLEND_FUNC_ONE_MINUS_CONST_ALPHA = 4'd13,
        ROP_BLEND_FUNC_ALPHA_SAT           = 4'd14
    } rop_blend_func_e;

    typedef struct packed {
        rop_blend_mode_e blend_mode_rgb;
        rop_blend_mode_e blend_mode_a;
        rop_blend_func_e blend_src_rgb;
        rop_blend_func_e blend_dst_rgb;
        rop_blend_func_e blend_src_a;
        rop_blend_func_e blend_dst_a;
        rgba_t           blend_const;
    } rop_dcrs_t;

    // Per-channel blend factors, same channel order as rgba_t.
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } blend_factor_t;

    // Exact round-to-nearest of p/255 for p in 0..255*255.
    function automatic logic [7:0] rop_div255(input logic [15:0] p);
        logic [16:0] t;
        logic [16:0] u;
        t = {1'b0, p} + 17'd128;
        u = t + {8'd0, t[16:8]};
        return 8'(u >> 8);
    endfunction

endpackage

// File: rtl/rop_blend_factor.sv
// Combinational blend-factor select for one source/destination colour pair.
// Instantiated once for the source factor and once for the destination factor.
//   src_i, dst_i     fragment and framebuffer colours
//   blend_const_i    constant blend colour
//   func_rgb_i       factor function for r/g/b
//   func_a_i         factor function for alpha
//   factor_o         selected 8-bit factor per channel
module rop_blend_factor
    import rop_types::*;
(
    input  rgba_t           src_i,
    input  rgba_t           dst_i,
    input  rgba_t           blend_const_i,
    input  rop_blend_func_e func_rgb_i,
    input  rop_blend_func_e func_a_i,
    output blend_factor_t   factor_o
);

    // 255-x is the bitwise complement for 8-bit values.
    function automatic logic [7:0] sel_factor(
        input rop_blend_func_e f,
        input logic [7:0]      s,
        input logic [7:0]      d,
        input logic [7:0]      c,
        input logic [7:0]      sa,
        input logic [7:0]      da,
        input logic [7:0]      ca,
        input logic [7:0]      sat
    );
        logic [7:0] r;
        case (f)
            ROP_BLEND_FUNC_ZERO:                  r = 8'h00;
            ROP_BLEND_FUNC_ONE:                   r = 8'hFF;
            ROP_BLEND_FUNC_SRC_COLOR:             r = s;
            ROP_BLEND_FUNC_ONE_MINUS_SRC_COLOR:   r = ~s;
            ROP_BLEND_FUNC_DST_COLOR:             r = d;
            ROP_BLEND_FUNC_ONE_MINUS_DST_COLOR:   r = ~d;
            ROP_BLEND_FUNC_SRC_ALPHA:             r = sa;
            ROP_BLEND_FUNC_ONE_MINUS_SRC_ALPHA:   r = ~sa;
            ROP_BLEND_FUNC_DST_ALPHA:             r = da;
            ROP_BLEND_FUNC_ONE_MINUS_DST_ALPHA:   r = ~da;
            ROP_BLEND_FUNC_CONST_COLOR:           r = c;
            ROP_BLEND_FUNC_ONE_MINUS_CONST_COLOR: r = ~c;
            ROP_BLEND_FUNC_CONST_ALPHA:           r = ca;
            ROP_BLEND_FUNC_ONE_MINUS_CONST_ALPHA: r = ~ca;
            ROP_BLEND_FUNC_ALPHA_SAT:             r = sat;
            default:                              r = 8'hFF;  // unused encoding acts as ONE
        endcase
        return r;
    endfunction

    logic [7:0] alpha_sat;

    assign alpha_sat = (src_i.a < ~dst_i.a) ? src_i.a : ~dst_i.a;

    assign factor_o.r = sel_factor(func_rgb_i, src_i.r, dst_i.r, blend_const_i.r,
                                   src_i.a, dst_i.a, blend_const_i.a, alpha_sat);
    assign factor_o.g = sel_factor(func_rgb_i, src_i.g, dst_i.g, blend_const_i.g,
                                   src_i.a, dst_i.a, blend_const_i.a, alpha_sat);
    assign factor_o.b = sel_factor(func_rgb_i, src_i.b, dst_i.b, blend_const_i.b,
                                   src_i.a, dst_i.a, blend_const_i.a, alpha_sat);
    // ALPHA_SAT on the alpha channel is defined as 255.
    assign factor_o.a = sel_factor(func_a_i, src_i.a, dst_i.a, blend_const_i.a,
                                   src_i.a, dst_i.a, blend_const_i.a, 8'hFF);

endmodule

// File: rtl/rop_blend_pipe.sv
// ROP colour blend stage: 2-stage elastic pipeline.
//   S1: factor select and 8 registered 16-bit products (src*Fs, dst*Fd).
//   S2: renormalise by 255, apply blend mode per channel group, clamp.
// Ports:
//   clk, reset_n             clock, async active-low reset
//   dcrs                     blend state, stable while any stage is valid
//   valid_in / ready_in      input handshake
//   src_color, dst_color     fragment and framebuffer colours (rgba_t layout)
//   tag_in / tag_out         opaque sideband, aligned with the colour
//   valid_out / ready_out    output handshake
//   color_out                blended colour
module rop_blend_pipe
    import rop_types::*;
#(
    parameter int TAG_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  rop_dcrs_t            dcrs,
    input  logic                 valid_in,
    output logic                 ready_in,
    input  logic [31:0]          src_color,
    input  logic [31:0]          dst_color,
    input  logic [TAG_WIDTH-1:0] tag_in,
    output logic                 valid_out,
    input  logic                 ready_out,
    output logic [31:0]          color_out,
    output logic [TAG_WIDTH-1:0] tag_out
);

    blend_factor_t         fs;
    blend_factor_t         fd;
    logic [3:0][7:0]       src_ch;
    logic [3:0][7:0]       dst_ch;
    logic [3:0][7:0]       fs_ch;
    logic [3:0][7:0]       fd_ch;
    logic [3:0][15:0]      ps_d;
    logic [3:0][15:0]      pd_d;

    logic                  valid1_q;
    logic [3:0][15:0]      ps_q;
    logic [3:0][15:0]      pd_q;
    logic [3:0][7:0]       src1_q;
    logic [3:0][7:0]       dst1_q;
    logic [TAG_WIDTH-1:0]  tag1_q;

    logic                  valid2_q;
    logic [3:0][7:0]       color2_d;
    logic [3:0][7:0]       color2_q;
    logic [TAG_WIDTH-1:0]  tag2_q;

    logic                  en1;
    logic                  en2;

    rop_blend_mode_e       mode_ch;
    logic [3:0][7:0]       ns;
    logic [3:0][7:0]       nd;
    logic [3:0][8:0]       sum9;
    logic [3:0][8:0]       dif9;
    logic [3:0][8:0]       rdif9;

    assign src_ch = src_color;
    assign dst_ch = dst_color;

    rop_blend_factor u_factor_src (
        .src_i         (src_color),
        .dst_i         (dst_color),
        .blend_const_i (dcrs.blend_const),
        .func_rgb_i    (dcrs.blend_src_rgb),
        .func_a_i      (dcrs.blend_src_a),
        .factor_o      (fs)
    );

    rop_blend_factor u_factor_dst (
        .src_i         (src_color),
        .dst_i         (dst_color),
        .blend_const_i (dcrs.blend_const),
        .func_rgb_i    (dcrs.blend_dst_rgb),
        .func_a_i      (dcrs.blend_dst_a),
        .factor_o      (fd)
    );

    assign fs_ch = fs;
    assign fd_ch = fd;

    always_comb begin
        ps_d = '0;
        pd_d = '0;
        for (int i = 0; i < 4; i++) begin
            ps_d[i] = 16'(src_ch[i]) * 16'(fs_ch[i]);
            pd_d[i] = 16'(dst_ch[i]) * 16'(fd_ch[i]);
        end
    end

    // Stage enables: a stage may load when empty or when it drains this cycle,
    // so a pop at S2 and a push at S1 in the same cycle leave no bubble.
    assign en2      = !valid2_q || ready_out;
    assign en1      = !valid1_q || en2;
    assign ready_in = en1;

    // Channel 3 is alpha and follows the alpha mode; the rest follow the rgb mode.
    // MIN/MAX operate on the raw colours carried through S1, ignoring factors.
    always_comb begin
        color2_d = '0;
        mode_ch  = ROP_BLEND_MODE_ADD;
        ns       = '0;
        nd       = '0;
        sum9     = '0;
        dif9     = '0;
        rdif9    = '0;
        for (int i = 0; i < 4; i++) begin
            mode_ch  = (i == 3) ? dcrs.blend_mode_a : dcrs.blend_mode_rgb;
            ns[i]    = rop_div255(ps_q[i]);
            nd[i]    = rop_div255(pd_q[i]);
            sum9[i]  = {1'b0, ns[i]} + {1'b0, nd[i]};
            dif9[i]  = {1'b0, ns[i]} - {1'b0, nd[i]};
            rdif9[i] = {1'b0, nd[i]} - {1'b0, ns[i]};
            case (mode_ch)
                ROP_BLEND_MODE_ADD:
                    color2_d[i] = sum9[i][8] ? 8'hFF : sum9[i][7:0];
                ROP_BLEND_MODE_SUBTRACT:
                    color2_d[i] = dif9[i][8] ? 8'h00 : dif9[i][7:0];
                ROP_BLEND_MODE_REV_SUBTRACT:
                    color2_d[i] = rdif9[i][8] ? 8'h00 : rdif9[i][7:0];
                ROP_BLEND_MODE_MIN:
                    color2_d[i] = (src1_q[i] < dst1_q[i]) ? src1_q[i] : dst1_q[i];
                ROP_BLEND_MODE_MAX:
                    color2_d[i] = (src1_q[i] > dst1_q[i]) ? src1_q[i] : dst1_q[i];
                default:
                    color2_d[i] = src1_q[i];
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid1_q <= 1'b0;
            ps_q     <= '0;
            pd_q     <= '0;
            src1_q   <= '0;
            dst1_q   <= '0;
            tag1_q   <= '0;
            valid2_q <= 1'b0;
            color2_q <= '0;
            tag2_q   <= '0;
        end else begin
            if (en1) begin
                valid1_q <= valid_in;
                if (valid_in) begin
                    ps_q   <= ps_d;
                    pd_q   <= pd_d;
                    src1_q <= src_ch;
                    dst1_q <= dst_ch;
                    tag1_q <= tag_in;
                end
            end
            if (en2) begin
                valid2_q <= valid1_q;
                if (valid1_q) begin
                    color2_q <= color2_d;
                    tag2_q   <= tag1_q;
                end
            end
        end
    end

    assign valid_out = valid2_q;
    assign color_out = color2_q;
    assign tag_out   = tag2_q;

endmodule

// File: tb/tb_rop_blend_pipe.sv
module tb_rop_blend_pipe;
    import rop_types::*;

    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    rop_dcrs_t     dcrs;
    logic          valid_in = 1'b0;
    logic          ready_in;
    logic [31:0]   src_color = '0;
    logic [31:0]   dst_color = '0;
    logic [TW-1:0] tag_in = '0;
    logic          valid_out;
    logic          ready_out = 1'b1;
    logic [31:0]   color_out;
    logic [TW-1:0] tag_out;

    rop_blend_pipe #(.TAG_WIDTH(TW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .dcrs      (dcrs),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .src_color (src_color),
        .dst_color (dst_color),
        .tag_in    (tag_in),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .color_out (color_out),
        .tag_out   (tag_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0]   color;
        logic [TW-1:0] tag;
        int            cyc;
    } sb_t;

    typedef struct {
        string       name;
        rop_dcrs_t   dcrs;
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] exp;
    } vec_t;

    sb_t   sbq[$];
    vec_t  vt[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    n_out = 0;
    bit    chk_lat = 1'b0;
    bit    rnd_ready = 1'b0;
    string cur_name = "init";

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%s]: got %h expected %h", name, cur_name, act, exp);
        end
    endtask

    function automatic rop_dcrs_t mk(input logic [2:0] mr, input logic [2:0] ma,
                                     input logic [3:0] sr, input logic [3:0] dr,
                                     input logic [3:0] sa, input logic [3:0] da,
                                     input logic [31:0] c);
        rop_dcrs_t x;
        x.blend_mode_rgb = rop_blend_mode_e'(mr);
        x.blend_mode_a   = rop_blend_mode_e'(ma);
        x.blend_src_rgb  = rop_blend_func_e'(sr);
        x.blend_dst_rgb  = rop_blend_func_e'(dr);
        x.blend_src_a    = rop_blend_func_e'(sa);
        x.blend_dst_a    = rop_blend_func_e'(da);
        x.blend_const    = c;
        return x;
    endfunction

    function automatic void add_vec(input string n, input rop_dcrs_t d,
                                    input logic [31:0] s, input logic [31:0] t,
                                    input logic [31:0] e);
        vec_t v;
        v.name = n; v.dcrs = d; v.src = s; v.dst = t; v.exp = e;
        vt.push_back(v);
    endfunction

    // Reference for source-over: rgb Fs=src.a Fd=1-src.a, alpha Fs=1 Fd=1-src.a.
    function automatic int rnd255(input int p);
        return (2 * p + 255) / 510;
    endfunction

    function automatic logic [31:0] model_over(input logic [31:0] s, input logic [31:0] d);
        logic [31:0] r;
        int sa = int'(s[31:24]);
        r = '0;
        for (int i = 0; i < 4; i++) begin
            int sc = int'((s >> (8 * i)) & 32'hFF);
            int dc = int'((d >> (8 * i)) & 32'hFF);
            int fs = (i == 3) ? 255 : sa;
            int v  = rnd255(sc * fs) + rnd255(dc * (255 - sa));
            if (v > 255) v = 255;
            r[8*i +: 8] = 8'(v);
        end
        return r;
    endfunction

    // Output monitor: scoreboard pop, latency, and hold-while-stalled checks.
    bit            hold_pend = 1'b0;
    logic [31:0]   hold_c;
    logic [TW-1:0] hold_t;
    always @(negedge clk) begin
        if (!reset_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 64'(valid_out), 64'd1);
                check("hold_color", 64'(color_out), 64'(hold_c));
                check("hold_tag", 64'(tag_out), 64'(hold_t));
            end
            hold_pend = valid_out && !ready_out;
            hold_c    = color_out;
            hold_t    = tag_out;
            if (valid_out && ready_out) begin
                n_out++;
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_out [%s]: got color %h tag %h, nothing expected",
                             cur_name, color_out, tag_out);
                end else begin
                    sb_t e;
                    e = sbq.pop_front();
                    check("color", 64'(color_out), 64'(e.color));
                    check("tag", 64'(tag_out), 64'(e.tag));
                    if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'd2);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_ready) ready_out = 1'($urandom_range(0, 1));
    end

    // Call just after a rising edge; returns just after the edge that accepted the input.
    task automatic send(input logic [31:0] s, input logic [31:0] d,
                        input logic [TW-1:0] t, input logic [31:0] e);
        int w = 0;
        sb_t x;
        src_color = s; dst_color = d; tag_in = t; valid_in = 1'b1;
        @(negedge clk);
        while (!ready_in && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!ready_in) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout [%s]: ready_in %b after %0d cycles, required 1", cur_name, ready_in, w);
        end else begin
            x.color = e; x.tag = t; x.cyc = cyc;
            sbq.push_back(x);
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((sbq.size() != 0 || valid_out) && w < 200) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (sbq.size() != 0 || valid_out) begin
            n_err++;
            $display("FAIL drain [%s]: %0d results still pending, required 0", cur_name, sbq.size());
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [2:0] M_ADD = ROP_BLEND_MODE_ADD;
    localparam logic [2:0] M_SUB = ROP_BLEND_MODE_SUBTRACT;
    localparam logic [2:0] M_REV = ROP_BLEND_MODE_REV_SUBTRACT;
    localparam logic [2:0] M_MIN = ROP_BLEND_MODE_MIN;
    localparam logic [2:0] M_MAX = ROP_BLEND_MODE_MAX;
    localparam logic [3:0] F_ZERO = ROP_BLEND_FUNC_ZERO;
    localparam logic [3:0] F_ONE  = ROP_BLEND_FUNC_ONE;
    localparam logic [3:0] F_SA   = ROP_BLEND_FUNC_SRC_ALPHA;
    localparam logic [3:0] F_OMSA = ROP_BLEND_FUNC_ONE_MINUS_SRC_ALPHA;
    localparam logic [3:0] F_DC   = ROP_BLEND_FUNC_DST_COLOR;
    localparam logic [3:0] F_CC   = ROP_BLEND_FUNC_CONST_COLOR;
    localparam logic [3:0] F_SAT  = ROP_BLEND_FUNC_ALPHA_SAT;

    initial begin
        int out0;

        dcrs = mk(M_ADD, M_ADD, F_ONE, F_ZERO, F_ONE, F_ZERO, 32'h0);

        add_vec("add_one_zero", mk(M_ADD, M_ADD, F_ONE, F_ZERO, F_ONE, F_ZERO, 32'h0),
                32'h80112233, 32'hFFFFFFFF, 32'h80112233);
        add_vec("add_src_over", mk(M_ADD, M_ADD, F_SA, F_OMSA, F_ONE, F_OMSA, 32'h0),
                32'h80FF0040, 32'h4000FF80, 32'hA0807F60);
        add_vec("add_sat", mk(M_ADD, M_ADD, F_ONE, F_ONE, F_ONE, F_ONE, 32'h0),
                32'h10C01020, 32'h20807010, 32'h30FF8030);
        add_vec("rev_sub_clamp", mk(M_REV, M_REV, F_ONE, F_ONE, F_ONE, F_ONE, 32'h0),
                32'h10C01020, 32'h20807010, 32'h10006000);
        add_vec("sub_clamp", mk(M_SUB, M_SUB, F_ONE, F_ONE, F_ONE, F_ONE, 32'h0),
                32'h10C01020, 32'h20807010, 32'h00400010);
        add_vec("min", mk(M_MIN, M_MIN, F_ZERO, F_ZERO, F_ZERO, F_ZERO, 32'h0),
                32'h10F02080, 32'h20E03070, 32'h10E02070);
        add_vec("max", mk(M_MAX, M_MAX, F_ZERO, F_ZERO, F_ZERO, F_ZERO, 32'h0),
                32'h10F02080, 32'h20E03070, 32'h20F03080);
        add_vec("mode_unused", mk(3'd5, 3'd7, F_ZERO, F_ZERO, F_ZERO, F_ZERO, 32'h0),
                32'h12345678, 32'h9ABCDEF0, 32'h12345678);
        add_vec("func_unused", mk(M_ADD, M_ADD, 4'd15, F_ZERO, 4'd15, F_ZERO, 32'h0),
                32'hA5C33C5A, 32'hFFFFFFFF, 32'hA5C33C5A);
        add_vec("const_color", mk(M_ADD, M_ADD, F_CC, F_ZERO, F_CC, F_ZERO, 32'h80FF0040),
                32'hFF80FF80, 32'h00000000, 32'h80800020);
        add_vec("alpha_sat", mk(M_ADD, M_ADD, F_SAT, F_ZERO, F_SAT, F_ZERO, 32'h0),
                32'hC0FF8000, 32'h80000000, 32'hC07F4000);
        add_vec("dst_color", mk(M_ADD, M_ADD, F_DC, F_ZERO, F_DC, F_ZERO, 32'h0),
                32'hFFFFFFFF, 32'h40102030, 32'h40102030);

        // Reset state.
        cur_name = "reset_state";
        #3;
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_color_out", 64'(color_out), 64'd0);
        check("rst_tag_out", 64'(tag_out), 64'd0);
        check("rst_ready_in", 64'(ready_in), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Table of directed vectors, one transaction each with ready_out high.
        chk_lat = 1'b1;
        foreach (vt[i]) begin
            cur_name = vt[i].name;
            dcrs = vt[i].dcrs;
            send(vt[i].src, vt[i].dst, TW'(i + 1), vt[i].exp);
            drain();
        end

        // Back-to-back source-over with random backpressure.
        cur_name = "random_stream";
        chk_lat = 1'b0;
        dcrs = mk(M_ADD, M_ADD, F_SA, F_OMSA, F_ONE, F_OMSA, 32'h0);
        out0 = n_out;
        rnd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [31:0] s;
            logic [31:0] d;
            s = $urandom;
            d = $urandom;
            send(s, d, TW'(8'h40 + i), model_over(s, d));
        end
        rnd_ready = 1'b0;
        ready_out = 1'b1;
        drain();
        check("stream_count", 64'(n_out - out0), 64'd16);

        // Reset with two transactions in flight.
        cur_name = "reset_in_flight";
        dcrs = mk(M_ADD, M_ADD, F_ONE, F_ZERO, F_ONE, F_ZERO, 32'h0);
        ready_out = 1'b0;
        send(32'h11111111, 32'h0, 8'hE1, 32'h11111111);
        send(32'h22222222, 32'h0, 8'hE2, 32'h22222222);
        check("pre_rst_valid", 64'(valid_out), 64'd1);
        check("pre_rst_ready_in", 64'(ready_in), 64'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_fl_valid_out", 64'(valid_out), 64'd0);
        check("rst_fl_color_out", 64'(color_out), 64'd0);
        check("rst_fl_tag_out", 64'(tag_out), 64'd0);
        sbq.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready_in", 64'(ready_in), 64'd1);
        check("post_rst_valid_out", 64'(valid_out), 64'd0);
        @(posedge clk);
        #1;
        ready_out = 1'b1;
        chk_lat = 1'b1;
        cur_name = "after_reset";
        send(32'h80112233, 32'hFFFFFFFF, 8'h5A, 32'h80112233);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
